// File: rtl/datapath_seq_pkg.sv
// Shared constants and state encoding for the datapath sequencer.
// The opcodes, ALU function codes and status bit positions match the datapath's encoding.
package datapath_seq_pkg;

  localparam int DATA_W   = 64;
  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 31;

  localparam logic [2:0] OP_LDI    = 3'b000;
  localparam logic [2:0] OP_ALU_RR = 3'b001;
  localparam logic [2:0] OP_ALU_RI = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;
  localparam logic [2:0] OP_LOAD   = 3'b100;

  localparam logic [4:0] FS_PASS = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;

  // Bit positions inside the {V,C,N,Z} status word
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_LD_ADDR = 3'd2,
    S_LD_WB   = 3'd3,
    S_ERR     = 3'd4
  } state_e;

  function automatic logic is_final(input state_e s);
    return (s == S_EXEC) || (s == S_LD_WB) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/datapath_sequencer_cw_encode.sv
// Combinational control-word encoder: maps the upcoming state and latched command
// to the datapath control fields. IDLE and ERR keep the previous fields but drop both write enables.
module seq_cw_encode
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31
) (
  input  state_e              state_i,
  input  logic [2:0]          op_i,
  input  logic [REG_AW-1:0]   rd_i,
  input  logic [REG_AW-1:0]   ra_i,
  input  logic [REG_AW-1:0]   rb_i,
  input  logic [DATA_W-1:0]   imm_i,
  input  logic [4:0]          fs_i,
  input  logic [REG_AW-1:0]   hold_da_i,
  input  logic [REG_AW-1:0]   hold_sa_i,
  input  logic [REG_AW-1:0]   hold_sb_i,
  input  logic [DATA_W-1:0]   hold_k_i,
  input  logic                hold_bs_i,
  input  logic [4:0]          hold_fs_i,
  input  logic                hold_sel_i,
  output logic [REG_AW-1:0]   da_o,
  output logic [REG_AW-1:0]   sa_o,
  output logic [REG_AW-1:0]   sb_o,
  output logic                w_o,
  output logic [DATA_W-1:0]   k_o,
  output logic                bs_o,
  output logic [4:0]          fs_o,
  output logic                write_o,
  output logic                sel_o
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic wr_ok_s;
  assign wr_ok_s = (rd_i != ZR);

  // Control-word selection by state and opcode
  always_comb begin
    da_o    = hold_da_i;
    sa_o    = hold_sa_i;
    sb_o    = hold_sb_i;
    k_o     = hold_k_i;
    bs_o    = hold_bs_i;
    fs_o    = hold_fs_i;
    sel_o   = hold_sel_i;
    w_o     = 1'b0;
    write_o = 1'b0;
    case (state_i)
      S_EXEC: begin
        da_o  = rd_i;
        sa_o  = ra_i;
        sb_o  = rb_i;
        k_o   = imm_i;
        sel_o = 1'b1;
        w_o   = wr_ok_s;
        case (op_i)
          OP_LDI: begin
            sa_o = ZR;
            bs_o = 1'b1;
            fs_o = FS_PASS;
          end
          OP_ALU_RR: begin
            bs_o = 1'b0;
            fs_o = fs_i;
          end
          OP_ALU_RI: begin
            bs_o = 1'b1;
            fs_o = fs_i;
          end
          OP_STORE: begin
            bs_o    = 1'b1;
            fs_o    = FS_ADD;
            w_o     = 1'b0;
            write_o = 1'b1;
          end
          default: begin
            w_o = 1'b0;
          end
        endcase
      end
      S_LD_ADDR, S_LD_WB: begin
        da_o  = rd_i;
        sa_o  = ra_i;
        sb_o  = rb_i;
        k_o   = imm_i;
        bs_o  = 1'b1;
        fs_o  = FS_ADD;
        sel_o = 1'b0;
        w_o   = (state_i == S_LD_WB) && wr_ok_s;
      end
      default: begin
        w_o     = 1'b0;
        write_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Command sequencer for the register-file/ALU/RAM datapath: accepts macro-commands on a
// valid/ready handshake and emits a registered per-cycle control word plus a done pulse.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [4:0]        cmd_fs,
  input  logic              cmd_setflags,
  output logic [REG_AW-1:0] DA,
  output logic [REG_AW-1:0] SA,
  output logic [REG_AW-1:0] SB,
  output logic              W,
  output logic [DATA_W-1:0] K,
  output logic              BS,
  output logic [4:0]        FS,
  output logic              write,
  output logic              selEN,
  input  logic [3:0]        status,
  output logic              done,
  output logic              done_err,
  output logic [3:0]        flags
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        cfs_q, cfs_d;
  logic              sf_q, sf_d;

  logic [REG_AW-1:0] da_q, da_d, sa_q, sa_d, sb_q, sb_d;
  logic [DATA_W-1:0] k_q, k_d;
  logic [4:0]        fs_q, fs_d;
  logic              w_q, w_d, bs_q, bs_d, wr_q, wr_d, sel_q, sel_d;
  logic              done_q, done_d, err_q, err_d;
  logic [3:0]        flags_q, flags_d;
  logic              accept_s;

  assign cmd_ready = (state_q != S_LD_ADDR);
  assign accept_s  = cmd_valid && cmd_ready;

  // Next state, command latch, completion and flag capture
  always_comb begin
    state_d = S_IDLE;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    imm_d   = imm_q;
    cfs_d   = cfs_q;
    sf_d    = sf_q;
    if (accept_s) begin
      op_d  = cmd_op;
      rd_d  = cmd_rd;
      ra_d  = cmd_ra;
      rb_d  = cmd_rb;
      imm_d = cmd_imm;
      cfs_d = cmd_fs;
      sf_d  = cmd_setflags;
      case (cmd_op)
        OP_LDI, OP_ALU_RR, OP_ALU_RI, OP_STORE: state_d = S_EXEC;
        OP_LOAD:                                state_d = S_LD_ADDR;
        default:                                state_d = S_ERR;
      endcase
    end else if (state_q == S_LD_ADDR) begin
      state_d = S_LD_WB;
    end else begin
      state_d = S_IDLE;
    end
    done_d = is_final(state_q);
    err_d  = (state_q == S_ERR);
    if ((state_q == S_EXEC) && sf_q && ((op_q == OP_ALU_RR) || (op_q == OP_ALU_RI))) begin
      flags_d = status;
    end else begin
      flags_d = flags_q;
    end
  end

  // Encoding from the upcoming state keeps the control word in step with that state
  seq_cw_encode #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .ZERO_REG (ZERO_REG)
  ) u_cw_encode (
    .state_i    (state_d),
    .op_i       (op_d),
    .rd_i       (rd_d),
    .ra_i       (ra_d),
    .rb_i       (rb_d),
    .imm_i      (imm_d),
    .fs_i       (cfs_d),
    .hold_da_i  (da_q),
    .hold_sa_i  (sa_q),
    .hold_sb_i  (sb_q),
    .hold_k_i   (k_q),
    .hold_bs_i  (bs_q),
    .hold_fs_i  (fs_q),
    .hold_sel_i (sel_q),
    .da_o       (da_d),
    .sa_o       (sa_d),
    .sb_o       (sb_d),
    .w_o        (w_d),
    .k_o        (k_d),
    .bs_o       (bs_d),
    .fs_o       (fs_d),
    .write_o    (wr_d),
    .sel_o      (sel_d)
  );

  // State, latched command and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
      cfs_q   <= 5'b00000;
      sf_q    <= 1'b0;
      da_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      k_q     <= '0;
      fs_q    <= 5'b00000;
      w_q     <= 1'b0;
      bs_q    <= 1'b0;
      wr_q    <= 1'b0;
      sel_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      imm_q   <= imm_d;
      cfs_q   <= cfs_d;
      sf_q    <= sf_d;
      da_q    <= da_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      k_q     <= k_d;
      fs_q    <= fs_d;
      w_q     <= w_d;
      bs_q    <= bs_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
      flags_q <= flags_d;
    end
  end

  assign DA       = da_q;
  assign SA       = sa_q;
  assign SB       = sb_q;
  assign W        = w_q;
  assign K        = k_q;
  assign BS       = bs_q;
  assign FS       = fs_q;
  assign write    = wr_q;
  assign selEN    = sel_q;
  assign done     = done_q;
  assign done_err = err_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a datapath model executes the DUT's control words while an
// architectural command model predicts register/RAM contents, flags and the per-cycle schedule.
module tb_datapath_sequencer;
  import datapath_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_setflags;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_ra, cmd_rb, cmd_fs;
  logic [63:0] cmd_imm;
  logic [4:0]  DA, SA, SB, FS;
  logic        W, BS, write, selEN, done, done_err;
  logic [63:0] K;
  logic [3:0]  status, flags;

  always #5 clock = ~clock;

  datapath_sequencer dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .cmd_fs(cmd_fs), .cmd_setflags(cmd_setflags),
    .DA(DA), .SA(SA), .SB(SB), .W(W), .K(K), .BS(BS), .FS(FS), .write(write),
    .selEN(selEN), .status(status), .done(done), .done_err(done_err), .flags(flags)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd, ra, rb;
    logic [63:0] imm;
    logic [4:0]  fs;
    logic        sf;
  } cmd_t;

  typedef struct packed {
    logic [4:0]  da, sa, sb;
    logic        w;
    logic [63:0] k;
    logic        bs;
    logic [4:0]  fs;
    logic        wr, sel;
  } cw_t;

  typedef enum int {K_IDLE, K_EXEC, K_LDA, K_LDWB, K_ERR} kind_e;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Datapath ALU: returns {V,C,N,Z, result}
  function automatic logic [67:0] alu(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (f)
      5'b00100: r = b;
      5'b01000: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      5'b01100: r = a ^ b;
      5'b10000: r = a << b[5:0];
      default:  r = a & b;
    endcase
    return {v, c, r[63], (r == 64'd0), r};
  endfunction

  // ---------------- datapath model driven by the DUT's control word ----------------
  logic [63:0] dp_regs [32] = '{default: 64'd0};
  logic [63:0] dp_ram  [256] = '{default: 64'd0};
  logic [63:0] dp_a, dp_b, dp_f, dp_bus, dp_sb;

  always_comb begin
    dp_a  = (SA == 5'd31) ? 64'd0 : dp_regs[SA];
    dp_sb = (SB == 5'd31) ? 64'd0 : dp_regs[SB];
    dp_b  = BS ? K : dp_sb;
    {status, dp_f} = alu(FS, dp_a, dp_b);
    dp_bus = selEN ? dp_f : dp_ram[dp_f[7:0]];
  end

  always @(posedge clock) begin
    if (W && (DA != 5'd31)) dp_regs[DA] <= dp_bus;
    if (write) dp_ram[dp_f[7:0]] <= dp_sb;
  end

  // ---------------- architectural reference model ----------------
  logic [63:0] ref_regs [32] = '{default: 64'd0};
  logic [63:0] ref_ram  [256] = '{default: 64'd0};
  kind_e       cur_k = K_IDLE;
  cmd_t        cur_c = '0;
  logic        exp_done = 1'b0, exp_err = 1'b0;
  logic [3:0]  exp_flags = 4'd0;
  cmd_t        pend[$];
  int          gap_pct = 0;

  function automatic logic [63:0] rdreg(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : ref_regs[r];
  endfunction

  task automatic commit(input cmd_t c);
    logic [67:0] res;
    logic [63:0] sum;
    case (c.op)
      OP_LDI: if (c.rd != 5'd31) ref_regs[c.rd] = c.imm;
      OP_ALU_RR, OP_ALU_RI: begin
        res = alu(c.fs, rdreg(c.ra), (c.op == OP_ALU_RR) ? rdreg(c.rb) : c.imm);
        if (c.rd != 5'd31) ref_regs[c.rd] = res[63:0];
        if (c.sf) exp_flags = res[67:64];
      end
      OP_STORE: begin
        sum = rdreg(c.ra) + c.imm;
        ref_ram[sum[7:0]] = rdreg(c.rb);
      end
      OP_LOAD: begin
        sum = rdreg(c.ra) + c.imm;
        if (c.rd != 5'd31) ref_regs[c.rd] = ref_ram[sum[7:0]];
      end
      default: ;
    endcase
  endtask

  function automatic kind_e first_kind(input logic [2:0] op);
    if (op <= OP_STORE) return K_EXEC;
    if (op == OP_LOAD) return K_LDA;
    return K_ERR;
  endfunction

  // Which control fields are defined for a cycle, and their values
  task automatic exp_cw(input kind_e kd, input cmd_t c, output cw_t v, output cw_t m);
    v = '0;
    m = '0;
    m.w = 1'b1;
    m.wr = 1'b1;
    if (kd == K_EXEC) begin
      m.sel = 1'b1; v.sel = 1'b1;
      m.bs = 1'b1; m.fs = '1; m.sa = '1; v.sa = c.ra;
      if (c.op == OP_STORE) begin
        m.sb = '1; v.sb = c.rb; m.k = '1; v.k = c.imm;
        v.bs = 1'b1; v.fs = FS_ADD; v.wr = 1'b1;
      end else begin
        m.da = '1; v.da = c.rd; v.w = (c.rd != 5'd31);
        if (c.op == OP_LDI) begin
          v.sa = 5'd31; m.k = '1; v.k = c.imm; v.bs = 1'b1; v.fs = FS_PASS;
        end else if (c.op == OP_ALU_RR) begin
          m.sb = '1; v.sb = c.rb; v.bs = 1'b0; v.fs = c.fs;
        end else begin
          m.k = '1; v.k = c.imm; v.bs = 1'b1; v.fs = c.fs;
        end
      end
    end else if (kd == K_LDA || kd == K_LDWB) begin
      m.sa = '1; v.sa = c.ra; m.k = '1; v.k = c.imm; m.bs = 1'b1; v.bs = 1'b1;
      m.fs = '1; v.fs = FS_ADD; m.sel = 1'b1; v.sel = 1'b0;
      if (kd == K_LDWB) begin
        m.da = '1; v.da = c.rd; v.w = (c.rd != 5'd31);
      end
    end
  endtask

  task automatic drive(input cmd_t c);
    cmd_op = c.op; cmd_rd = c.rd; cmd_ra = c.ra; cmd_rb = c.rb;
    cmd_imm = c.imm; cmd_fs = c.fs; cmd_setflags = c.sf;
  endtask

  function automatic cmd_t mk(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] ra,
                              input logic [4:0] rb, input logic [63:0] imm, input logic [4:0] fs,
                              input logic sf);
    cmd_t c;
    c.op = op; c.rd = rd; c.ra = ra; c.rb = rb; c.imm = imm; c.fs = fs; c.sf = sf;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4));
    c.rd = 5'($urandom_range(31));
    c.ra = 5'($urandom_range(31));
    c.rb = 5'($urandom_range(31));
    c.imm = ($urandom_range(1) == 0) ? 64'($urandom_range(255)) : {$urandom, $urandom};
    case ($urandom_range(3))
      0: c.fs = 5'b00100;
      1: c.fs = 5'b01000;
      2: c.fs = 5'b01100;
      default: c.fs = 5'b10000;
    endcase
    c.sf = 1'($urandom_range(1));
    return c;
  endfunction

  // One clock period: check outputs at the negedge, drive, advance the model
  task automatic cycle();
    cw_t  v, m, o;
    logic exp_ready, acc;
    exp_cw(cur_k, cur_c, v, m);
    o = {DA, SA, SB, W, K, BS, FS, write, selEN};
    check("ctrl_word", 128'(o & m), 128'(v & m));
    exp_ready = (cur_k != K_LDA);
    check("cmd_ready", 128'(cmd_ready), 128'(exp_ready));
    check("done", 128'(done), 128'(exp_done));
    if (exp_done) check("done_err", 128'(done_err), 128'(exp_err));
    check("flags", 128'(flags), 128'(exp_flags));
    acc = 1'b0;
    if (pend.size() > 0 && $urandom_range(99) >= gap_pct) begin
      cmd_valid = 1'b1;
      drive(pend[0]);
      acc = exp_ready;
    end else begin
      cmd_valid = 1'b0;
      drive(rand_cmd());
    end
    exp_done = (cur_k == K_EXEC) || (cur_k == K_LDWB) || (cur_k == K_ERR);
    exp_err  = (cur_k == K_ERR);
    if (cur_k == K_EXEC || cur_k == K_LDWB) commit(cur_c);
    if (acc) begin
      cur_c = pend.pop_front();
      cur_k = first_kind(cur_c.op);
    end else if (cur_k == K_LDA) begin
      cur_k = K_LDWB;
    end else begin
      cur_k = K_IDLE;
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() != 0 || cur_k != K_IDLE || exp_done) && n < 3000) begin
      cycle();
      n++;
    end
    check("drain", 128'(pend.size()), 128'(0));
  endtask

  initial begin
    cmd_valid = 1'b0;
    drive('0);
    repeat (2) @(negedge clock);
    check("rst_W", 128'(W), 128'(0));
    check("rst_write", 128'(write), 128'(0));
    check("rst_flags", 128'(flags), 128'(0));
    check("rst_ready", 128'(cmd_ready), 128'(1));
    check("rst_done", 128'(done), 128'(0));
    check("rst_selEN", 128'(selEN), 128'(1));
    reset = 1'b1;

    // Directed program from the bring-up plan, issued back-to-back
    pend.push_back(mk(OP_LDI,    5'd5,  5'd0,  5'd0,  64'd24, 5'd0,     1'b0));
    pend.push_back(mk(OP_LDI,    5'd7,  5'd0,  5'd0,  64'd39, 5'd0,     1'b0));
    pend.push_back(mk(OP_ALU_RR, 5'd1,  5'd5,  5'd7,  64'd0,  5'b01000, 1'b1));
    pend.push_back(mk(OP_ALU_RR, 5'd30, 5'd1,  5'd5,  64'd0,  5'b01100, 1'b0));
    pend.push_back(mk(OP_ALU_RI, 5'd17, 5'd30, 5'd0,  64'd2,  5'b10000, 1'b0));
    pend.push_back(mk(OP_STORE,  5'd0,  5'd7,  5'd17, 64'd0,  5'd0,     1'b0));
    pend.push_back(mk(OP_LOAD,   5'd0,  5'd7,  5'd0,  64'd0,  5'd0,     1'b0));
    pend.push_back(mk(3'b111,    5'd3,  5'd3,  5'd3,  64'd9,  5'd0,     1'b0));
    pend.push_back(mk(OP_LDI,    5'd31, 5'd0,  5'd0,  64'd123, 5'd0,    1'b0));
    gap_pct = 0;
    drain();
    check("R1", 128'(dp_regs[1]), 128'(63));
    check("R30", 128'(dp_regs[30]), 128'(39));
    check("R17", 128'(dp_regs[17]), 128'(156));
    check("M39", 128'(dp_ram[39]), 128'(156));
    check("R0", 128'(dp_regs[0]), 128'(156));
    check("flagZ", 128'(flags[ST_Z]), 128'(0));

    // Randomized command stream with idle gaps
    for (int i = 0; i < 150; i++) pend.push_back(rand_cmd());
    gap_pct = 30;
    drain();

    // Reset in the middle of a LOAD's address cycle
    gap_pct = 0;
    pend.push_back(mk(OP_LOAD, 5'd2, 5'd7, 5'd0, 64'd0, 5'd0, 1'b0));
    for (int i = 0; i < 10 && cur_k != K_LDA; i++) cycle();
    check("reached_ld_addr", 128'(cur_k == K_LDA), 128'(1));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_W", 128'(W), 128'(0));
    check("mid_rst_selEN", 128'(selEN), 128'(1));
    check("mid_rst_ready", 128'(cmd_ready), 128'(1));
    check("mid_rst_fields", 128'({DA, SA, SB, K, BS, FS, write}), 128'(0));
    check("mid_rst_flags", 128'(flags), 128'(0));
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_rst_done", 128'(done), 128'(0));
    reset = 1'b1;
    pend.delete();
    cur_k = K_IDLE;
    exp_done = 1'b0;
    exp_err = 1'b0;
    exp_flags = 4'd0;
    repeat (3) cycle();

    for (int i = 0; i < 32; i++) check($sformatf("reg%0d", i), 128'(dp_regs[i]), 128'(ref_regs[i]));
    for (int i = 0; i < 256; i++) check($sformatf("ram%0d", i), 128'(dp_ram[i]), 128'(ref_ram[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Command-driven controller that sequences the register-file/ALU/RAM datapath by generating its per-cycle control word (DA, SA, SB, W, K, BS, FS, write, selEN).
- Accepts one macro-command per valid/ready handshake and expands it into one or two datapath cycles.
- Returns a done pulse with the captured ALU status.
- Sits between the instruction source (test master or future fetch/decode) and the datapath.

Parameters:
- DATA_W, 64, width of K / immediate
- REG_AW, 5, register address width
- ZERO_REG, 31, hardwired-zero register index

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer accepts command this cycle
- cmd_op  in  3  opcode: 000 LDI, 001 ALU_RR, 010 ALU_RI, 011 STORE, 100 LOAD, others illegal
- cmd_rd, cmd_ra, cmd_rb  in  REG_AW each  destination / source A / source B
- cmd_imm  in  DATA_W  immediate or address offset
- cmd_fs  in  5  ALU function for ALU_RR/ALU_RI
- cmd_setflags  in  1  update flags from status
- DA, SA, SB  out  REG_AW each  datapath register addresses
- W  out  1  register write enable
- K  out  DATA_W  constant to datapath
- BS  out  1  B-select (1 = K)
- FS  out  5  ALU function
- write  out  1  RAM write enable
- selEN  out  1  bus source (1 = ALU, 0 = RAM)
- status  in  4  datapath ALU status {V,C,N,Z}
- done  out  1  one-cycle completion pulse
- done_err  out  1  valid with done; illegal opcode
- flags  out  4  last captured status

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; W=0, write=0, done=0, done_err=0, flags=0, selEN=1, BS=0, FS=0, DA=SA=SB=0, K=0. Applies immediately mid-operation; an in-flight command is dropped with no done.
- Control outputs are registered. Command accepted at edge T drives its first control cycle during T..T+1.
- States: IDLE, EXEC, LD_ADDR, LD_WB, ERR.
- cmd_ready=1 in IDLE and in each final cycle (EXEC, LD_WB, ERR). Accepting there goes directly to the next command's first state, giving back-to-back single-cycle ops at one per clock. cmd_ready=0 in LD_ADDR.
- LDI → EXEC: DA=rd, SA=ZERO_REG, K=imm, BS=1, FS=00100 (pass), W=1, selEN=1.
- ALU_RR → EXEC: DA=rd, SA=ra, SB=rb, BS=0, FS=cmd_fs, W=1, selEN=1.
- ALU_RI → EXEC: same as ALU_RR but BS=1, K=imm.
- STORE → EXEC: SA=ra, SB=rb, K=imm, BS=1, FS=01000 (add), write=1, W=0, selEN=1.
- LOAD → LD_ADDR then LD_WB.
  - LD_ADDR: SA=ra, K=imm, BS=1, FS=01000, selEN=0, W=0, write=0.
  - LD_WB: same address fields, DA=rd, W=1.
- Illegal op → ERR: W=0, write=0. done=1 and done_err=1 are asserted on the following edge.
- rd==ZERO_REG: W forced to 0; the command still completes normally.
- done pulses in the cycle after the final control cycle.
- flags capture status at the end of EXEC for ALU_RR/ALU_RI with cmd_setflags=1; otherwise flags hold.
- Leaving a final state with no new command → IDLE. In IDLE, W=0 and write=0; other fields hold.
- cmd_valid is ignored while cmd_ready=0. Command fields are sampled only on the handshake.

Decomposition:
- Package datapath_seq_pkg holds:
  - opcode localparams
  - FS_PASS=5'b00100, FS_ADD=5'b01000
  - state encoding
  - STATUS bit indices
- One sub-module: seq_cw_encode, a combinational mapping from {state, latched command} to the control word.

Test Plan:
- After reset, expect W=0, write=0, flags=0, cmd_ready=1.
- Preload registers: LDI R5,24 then LDI R7,39 back-to-back → 2 consecutive EXEC cycles; cmd_ready stays high; R5=24, R7=39.
- ALU_RR R1=R5+R7 (FS=01000, setflags), then ALU_RR R30=R1^R5 (FS=01100):
  - R1=63 with flags Z=0.
  - R30=39.
- ALU_RI R17=R30<<2 (FS=10000, imm=2) → R17=156.
- STORE M[R7+0]=R17 → write=1 for exactly one cycle, W=0, M[39]=156.
- LOAD R0=M[R7+0] → LD_ADDR (W=0, selEN=0) then LD_WB (W=1, DA=0); cmd_ready=0 during LD_ADDR; R0=156; done is 2 cycles after LD_ADDR starts.
- Boundary cases:
  - Illegal op 111 → done=1, done_err=1, no W or write pulse.
  - LDI to R31 → W stays 0.
  - Reset asserted during LD_ADDR → outputs to reset values immediately; no done.
